regbus_arbiter: RTL and testbench
=================================

# regbus_arbiter

Two-master arbiter and sequencer for the 12-bit/16-bit register bus that feeds the register file. It lets the SPI slave (master 0) and a second requester share the single register port (master 1), such as an on-chip startup-config loader or a debug UART. Each request pulse is buffered in a per-master pending slot. The arbiter grants pending slots round-robin and issues exactly one bus cycle at a time. It absorbs the register file's one-cycle registered read latency and returns read data to the owning master.

## Interface
- ADDR_W, 12, register address width
- DATA_W, 16, register data width
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- m0_wreq / m1_wreq  input  1  one-cycle write request pulse
- m0_rreq / m1_rreq  input  1  one-cycle read request pulse
- m0_addr / m1_addr  input  ADDR_W  address; sampled only in the request cycle
- m0_wdata / m1_wdata  input  DATA_W  write data; sampled only in the request cycle
- m0_busy / m1_busy  output  1  high while that master's slot is pending or in flight
- m0_done / m1_done  output  1  one-cycle pulse: transaction completed
- m0_rdata / m1_rdata  output  DATA_W  read result; valid in the done cycle of a read, held until the next read completes
- m0_ovf / m1_ovf  output  1  one-cycle pulse: a request was dropped
- bus_wreq  output  1  one-cycle write strobe to the register file
- bus_rreq  output  1  one-cycle read strobe to the register file
- bus_addr  output  ADDR_W  registered address, held from issue until the transaction ends
- bus_wdata  output  DATA_W  registered write data
- bus_rdata  input  DATA_W  register file read data; registered there, valid one cycle after bus_addr

## Operation
- **Pending slot per master:** {valid, is_write, addr, wdata}.
  - A request pulse with busy low loads the slot at the clock edge; busy goes high next cycle.
  - A request pulse with busy high is dropped; ovf pulses the next cycle.
  - wreq and rreq in the same cycle: the write is taken, the read is dropped, ovf pulses.
  - A request in the same cycle that done pulses is accepted, because busy is already low.
- **FSM states:** IDLE, ISSUE, RWAIT.
  - IDLE: if any slot is valid, choose the winner, register its addr/wdata onto bus_addr/bus_wdata, record gnt, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive bus_wreq (write) or bus_rreq (read) for exactly this cycle.
    - Write: clear the slot, pulse done next cycle, return to IDLE.
    - Read: go to RWAIT.
  - RWAIT: bus_rdata is valid. Capture it into mN_rdata, clear the slot, pulse done next cycle, return to IDLE.
- **Round-robin:** register last_gnt, reset to 1 so master 0 wins the first contest.
  - Both slots valid in IDLE: grant the master that is not last_gnt.
  - One slot valid: grant it.
  - last_gnt updates on every grant.
- **Bus ownership:** bus_addr and bus_wdata change only on the IDLE→ISSUE transition. They hold their values through ISSUE and RWAIT.
- No starvation: with both masters continuously pending, grants alternate 0,1,0,1.

## Timing
- Reset values: all busy/done/ovf/bus_wreq/bus_rreq = 0; bus_addr = 0, bus_wdata = 0, mN_rdata = 0; state IDLE; slots invalid; last_gnt = 1.
- Write latency, with the request pulse at cycle T and an uncontested bus:
  - busy high at T+1
  - bus_wreq at T+2
  - done at T+3, with busy low at T+3
- Read latency, same conditions:
  - busy high at T+1
  - bus_rreq at T+2
  - bus_rdata captured at the end of T+3
  - done and rdata valid at T+4, with busy low at T+4
- Back-to-back throughput: one write per 2 cycles, or one read per 3 cycles, once the slots are pre-loaded.
- The other master's slot may load at any time, including while a transaction is in flight. It waits in its slot.
- Reset in any state, including mid-read: the next cycle is IDLE with reset values. In-flight and pending requests are discarded with no done pulse and no bus strobe.
- A master must never see done without a prior accepted request. There is exactly one done per accepted request.

## Test plan
- m0 write addr 0x005, data 0x1234 at T -> bus_wreq=1 with bus_addr=0x005 and bus_wdata=0x1234 at T+2; m0_done at T+3; register readback gives 0x1234.
- m1 read addr 0x005 after the above -> bus_rreq at T+2; m1_done at T+4 with m1_rdata=0x1234; m0 sees no done.
- m0 and m1 write in the same cycle (0x010 and 0x011) -> m0 issues first, then m1. Repeat with both continuously re-requesting for 8 transactions -> strict 0,1,0,1 alternation and no ovf.
- m0 second write pulse while m0_busy -> m0_ovf pulse the next cycle, only the first write reaches the bus; simultaneous m1 wreq and rreq -> only the write issues and m1_ovf pulses.
- rst asserted in the RWAIT cycle of an m1 read, with an m0 write pending -> no done, no further bus strobes, all outputs at reset values next cycle; a fresh m0 request afterwards completes normally.
- Request pulse in the exact cycle of the same master's done -> accepted with no ovf; completes at the normal latency measured from that pulse.

Source files
------------

// File: rtl/regbus_arbiter.sv
// rtl/regbus_arbiter.sv - two-master round-robin arbiter and sequencer for the register bus
module regbus_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_wreq,
    input  logic              m0_rreq,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_busy,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ovf,
    input  logic              m1_wreq,
    input  logic              m1_rreq,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_busy,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ovf,
    output logic              bus_wreq,
    output logic              bus_rreq,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RWAIT = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Per-master request view, indexed by master number.
    logic [1:0]        req_w;
    logic [1:0]        req_r;
    logic [ADDR_W-1:0] req_addr  [2];
    logic [DATA_W-1:0] req_wdata [2];

    // Pending slots: one buffered transaction per master.
    logic [1:0]        slot_valid_q;
    logic [1:0]        slot_write_q;
    logic [ADDR_W-1:0] slot_addr_q  [2];
    logic [DATA_W-1:0] slot_wdata_q [2];

    // Arbitration and sequencing.
    logic              gnt_q;
    logic              last_gnt_q;
    logic              grant_en;
    logic              winner;
    logic              complete;
    logic              capture;
    logic [1:0]        gnt_oh;
    logic [1:0]        done_d;
    logic [1:0]        ovf_d;

    // Registered outputs.
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic [1:0]        done_q;
    logic [1:0]        ovf_q;
    logic [DATA_W-1:0] rdata_q [2];

    assign req_w        = {m1_wreq, m0_wreq};
    assign req_r        = {m1_rreq, m0_rreq};
    assign req_addr[0]  = m0_addr;
    assign req_addr[1]  = m1_addr;
    assign req_wdata[0] = m0_wdata;
    assign req_wdata[1] = m1_wdata;

    assign gnt_oh = {gnt_q, ~gnt_q};

    // Drop detection: a request while the slot is occupied, or a read paired with a write.
    always_comb begin
        ovf_d = '0;
        for (int i = 0; i < 2; i++) begin
            ovf_d[i] = ((req_w[i] | req_r[i]) & slot_valid_q[i]) | (req_w[i] & req_r[i]);
        end
        done_d = complete ? gnt_oh : 2'b00;
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant selection and bus strobes.
    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        winner   = 1'b0;
        complete = 1'b0;
        capture  = 1'b0;
        bus_wreq = 1'b0;
        bus_rreq = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|slot_valid_q) begin
                    grant_en = 1'b1;
                    // Contest goes to whoever did not win last; otherwise the lone requester.
                    winner   = (&slot_valid_q) ? ~last_gnt_q : slot_valid_q[1];
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (slot_write_q[gnt_q]) begin
                    bus_wreq = 1'b1;
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    bus_rreq = 1'b1;
                    state_d  = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                // Register file returns data one cycle after the read strobe.
                capture  = 1'b1;
                complete = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending slots: load on an accepted request, clear when the owning transaction ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q <= '0;
            slot_write_q <= '0;
            for (int i = 0; i < 2; i++) begin
                slot_addr_q[i]  <= '0;
                slot_wdata_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (complete && gnt_oh[i]) begin
                    slot_valid_q[i] <= 1'b0;
                end else if (!slot_valid_q[i] && (req_w[i] || req_r[i])) begin
                    slot_valid_q[i] <= 1'b1;
                    slot_write_q[i] <= req_w[i];
                    slot_addr_q[i]  <= req_addr[i];
                    slot_wdata_q[i] <= req_wdata[i];
                end
            end
        end
    end

    // Grant bookkeeping and bus address/data, which move only when a grant is made.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else if (grant_en) begin
            gnt_q       <= winner;
            last_gnt_q  <= winner;
            bus_addr_q  <= slot_addr_q[winner];
            bus_wdata_q <= slot_wdata_q[winner];
        end
    end

    // Per-master completion pulses, drop pulses and read-data holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= '0;
            ovf_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            done_q <= done_d;
            ovf_q  <= ovf_d;
            for (int i = 0; i < 2; i++) begin
                if (capture && gnt_oh[i]) begin
                    rdata_q[i] <= bus_rdata;
                end
            end
        end
    end

    assign m0_busy   = slot_valid_q[0];
    assign m1_busy   = slot_valid_q[1];
    assign m0_done   = done_q[0];
    assign m1_done   = done_q[1];
    assign m0_ovf    = ovf_q[0];
    assign m1_ovf    = ovf_q[1];
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_regbus_arbiter.sv
// tb/tb_regbus_arbiter.sv - scoreboard testbench for regbus_arbiter
module tb_regbus_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    wreq_v = '0;
    logic [1:0]    rreq_v = '0;
    logic [AW-1:0] addr_v  [2];
    logic [DW-1:0] wdata_v [2];

    logic          m0_busy, m1_busy, m0_done, m1_done, m0_ovf, m1_ovf;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          bus_wreq, bus_rreq;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata = '0;

    logic [DW-1:0] mem     [4096];
    logic [DW-1:0] mdl_mem [4096];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    regbus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_wreq(wreq_v[0]), .m0_rreq(rreq_v[0]), .m0_addr(addr_v[0]), .m0_wdata(wdata_v[0]),
        .m0_busy(m0_busy), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_ovf(m0_ovf),
        .m1_wreq(wreq_v[1]), .m1_rreq(rreq_v[1]), .m1_addr(addr_v[1]), .m1_wdata(wdata_v[1]),
        .m1_busy(m1_busy), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_ovf(m1_ovf),
        .bus_wreq(bus_wreq), .bus_rreq(bus_rreq), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Register file: write on strobe, registered read data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus_wreq) mem[bus_addr] <= bus_wdata;
        if (bus_rreq) bus_rdata <= mem[bus_addr];
    end

    // Transaction-level reference model state.
    typedef struct { int c; bit wr; logic [AW-1:0] a; logic [DW-1:0] d; } bus_t;
    typedef struct { int c; int m; bit rd; logic [DW-1:0] d; } done_t;
    bus_t  bus_q[$];
    done_t dq[$];

    bit            pend [2];
    bit            infl [2];
    bit            pwr  [2];
    logic [AW-1:0] paddr[2];
    logic [DW-1:0] pdata[2];
    int            done_at[2];
    int            free_at  = 0;
    int            last     = 1;
    bit            ovf_now [2];
    bit            ovf_next[2];
    logic [AW-1:0] eaddr = '0, eaddr_nx = '0;
    logic [DW-1:0] ewd = '0, ewd_nx = '0;
    logic [DW-1:0] held[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    endtask

    function automatic bit model_busy(input int m);
        return pend[m] && !(infl[m] && done_at[m] == cyc);
    endfunction

    // Monitor and model step, mid-cycle.
    always @(negedge clk) begin : mon
        logic [1:0]    busy_a, done_a, ovf_a;
        logic [DW-1:0] rd_a [2];
        int            idx;
        bit            cand0, cand1;
        int            g;
        busy_a = {m1_busy, m0_busy};
        done_a = {m1_done, m0_done};
        ovf_a  = {m1_ovf, m0_ovf};
        rd_a[0] = m0_rdata;
        rd_a[1] = m1_rdata;

        ovf_now = ovf_next;
        ovf_next[0] = 1'b0;
        ovf_next[1] = 1'b0;
        eaddr = eaddr_nx;
        ewd   = ewd_nx;
        for (int m = 0; m < 2; m++) begin
            if (infl[m] && done_at[m] == cyc) begin
                pend[m] = 1'b0;
                infl[m] = 1'b0;
            end
        end

        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d_busy", m), 32'(busy_a[m]), 32'(pend[m]));
            chk($sformatf("m%0d_ovf", m), 32'(ovf_a[m]), 32'(ovf_now[m]));
            idx = -1;
            for (int k = 0; k < dq.size(); k++) begin
                if (dq[k].m == m) begin
                    idx = k;
                    break;
                end
            end
            if (done_a[m]) begin
                if (idx < 0) begin
                    fail_now($sformatf("m%0d_done_unexpected", m), 32'd1, 32'd0);
                end else begin
                    chk($sformatf("m%0d_done_cycle", m), 32'(cyc), 32'(dq[idx].c));
                    if (dq[idx].rd) held[m] = dq[idx].d;
                    dq.delete(idx);
                end
            end else if (idx >= 0 && dq[idx].c <= cyc) begin
                fail_now($sformatf("m%0d_done_missing", m), 32'd0, 32'd1);
                dq.delete(idx);
            end
            chk($sformatf("m%0d_rdata", m), 32'(rd_a[m]), 32'(held[m]));
        end

        if (bus_wreq && bus_rreq) fail_now("bus_both_strobes", 32'd1, 32'd0);
        if (bus_wreq || bus_rreq) begin
            if (bus_q.size() == 0) begin
                fail_now("bus_strobe_unexpected", 32'd1, 32'd0);
            end else begin
                chk("bus_strobe_cycle", 32'(cyc), 32'(bus_q[0].c));
                chk("bus_is_write", 32'(bus_wreq), 32'(bus_q[0].wr));
                chk("bus_strobe_addr", 32'(bus_addr), 32'(bus_q[0].a));
                if (bus_q[0].wr) chk("bus_strobe_wdata", 32'(bus_wdata), 32'(bus_q[0].d));
                void'(bus_q.pop_front());
            end
        end else if (bus_q.size() != 0 && bus_q[0].c <= cyc) begin
            fail_now("bus_strobe_missing", 32'd0, 32'd1);
            void'(bus_q.pop_front());
        end
        chk("bus_addr_hold", 32'(bus_addr), 32'(eaddr));
        chk("bus_wdata_hold", 32'(bus_wdata), 32'(ewd));

        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                pend[m] = 1'b0;
                infl[m] = 1'b0;
                held[m] = '0;
            end
            free_at  = cyc + 1;
            last     = 1;
            eaddr_nx = '0;
            ewd_nx   = '0;
            bus_q = bus_q.find(x) with (x.c <= cyc);
            dq    = dq.find(x) with (x.c <= cyc);
        end else begin
            if (cyc >= free_at) begin
                cand0 = pend[0] && !infl[0];
                cand1 = pend[1] && !infl[1];
                if (cand0 || cand1) begin
                    g = (cand0 && cand1) ? 1 - last : (cand0 ? 0 : 1);
                    last = g;
                    infl[g] = 1'b1;
                    bus_q.push_back('{cyc + 1, pwr[g], paddr[g], pdata[g]});
                    eaddr_nx = paddr[g];
                    ewd_nx   = pdata[g];
                    if (pwr[g]) begin
                        mdl_mem[paddr[g]] = pdata[g];
                        done_at[g] = cyc + 2;
                        dq.push_back('{cyc + 2, g, 1'b0, '0});
                    end else begin
                        done_at[g] = cyc + 3;
                        dq.push_back('{cyc + 3, g, 1'b1, mdl_mem[paddr[g]]});
                    end
                    free_at = done_at[g];
                end
            end
            for (int m = 0; m < 2; m++) begin
                if (wreq_v[m] || rreq_v[m]) begin
                    if (pend[m]) begin
                        ovf_next[m] = 1'b1;
                    end else begin
                        pend[m]  = 1'b1;
                        pwr[m]   = wreq_v[m];
                        paddr[m] = addr_v[m];
                        pdata[m] = wdata_v[m];
                        if (wreq_v[m] && rreq_v[m]) ovf_next[m] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit w0, input bit r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input bit w1, input bit r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          input bit r);
        wreq_v     = {w1, w0};
        rreq_v     = {r1, r0};
        addr_v[0]  = a0;
        addr_v[1]  = a1;
        wdata_v[0] = d0;
        wdata_v[1] = d1;
        rst        = r;
    endtask

    task automatic drive(input bit w0, input bit r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit w1, input bit r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input bit r);
        next_cycle();
        set_in(w0, r0, a0, d0, w1, r1, a1, d1, r);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    initial begin
        int n;
        bit w0, r0, w1, r1, rr;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = '0;
            mdl_mem[i] = '0;
        end
        for (int m = 0; m < 2; m++) begin
            addr_v[m] = '0; wdata_v[m] = '0; held[m] = '0; done_at[m] = -1;
            pend[m] = 0; infl[m] = 0; ovf_now[m] = 0; ovf_next[m] = 0;
        end
        repeat (3) drive(0, 0, '0, '0, 0, 0, '0, '0, 1);
        idle(2);

        // m0 write then m1 read of the same register
        drive(1, 0, 12'h005, 16'h1234, 0, 0, '0, '0, 0);
        idle(5);
        drive(0, 0, '0, '0, 0, 1, 12'h005, 16'h0000, 0);
        idle(6);

        // simultaneous writes, then continuous re-requesting
        drive(1, 0, 12'h010, 16'hA010, 1, 0, 12'h011, 16'hB011, 0);
        n = 0;
        for (int i = 0; i < 60 && n < 8; i++) begin
            next_cycle();
            w0 = model_busy(0) ? 1'b0 : (n < 8);
            if (w0) n++;
            w1 = model_busy(1) ? 1'b0 : (n < 8);
            if (w1) n++;
            set_in(w0, 0, 12'h010, DW'($urandom), w1, 0, 12'h011, DW'($urandom), 0);
        end
        idle(6);

        // overflow: second write while busy; write+read together
        drive(1, 0, 12'h030, 16'h3030, 0, 0, '0, '0, 0);
        drive(1, 0, 12'h031, 16'h3131, 1, 1, 12'h032, 16'h3232, 0);
        idle(8);

        // reset during RWAIT of an m1 read with an m0 write pending
        drive(0, 0, '0, '0, 0, 1, 12'h030, '0, 0);
        drive(1, 0, 12'h040, 16'h4040, 0, 0, '0, '0, 0);
        idle(1);
        drive(0, 0, '0, '0, 0, 0, '0, '0, 1);
        idle(2);
        drive(1, 0, 12'h041, 16'h4141, 0, 0, '0, '0, 0);
        idle(5);

        // request in the same cycle as done
        drive(1, 0, 12'h050, 16'h5050, 0, 0, '0, '0, 0);
        idle(2);
        drive(0, 1, 12'h050, 16'h0000, 0, 0, '0, '0, 0);
        idle(6);

        // randomized traffic with occasional reset
        for (int i = 0; i < 500; i++) begin
            w0 = ($urandom_range(0, 3) == 0);
            r0 = !w0 && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin w0 = 1; r0 = 1; end
            w1 = ($urandom_range(0, 3) == 0);
            r1 = !w1 && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin w1 = 1; r1 = 1; end
            rr = ($urandom_range(0, 119) == 0);
            drive(w0, r0, AW'($urandom_range(0, 7)), DW'($urandom),
                  w1, r1, AW'($urandom_range(0, 7)), DW'($urandom), rr);
        end
        idle(12);

        if (bus_q.size() != 0) fail_now("bus_queue_leftover", 32'(bus_q.size()), 32'd0);
        if (dq.size() != 0) fail_now("done_queue_leftover", 32'(dq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
